// File: rtl/queue_ctrl_pkg.sv
// Shared constants, FSM state type and the row-decode helper for the
// 8-entry register-file queue controller.
package queue_ctrl_pkg;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  // Occupancy value that means every row holds a live word.
  localparam logic [PTR_W:0] CNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } q_state_e;

  // demux8-style decode: a single 1 routed to row idx.
  function automatic logic [DEPTH-1:0] onehot8(input logic [PTR_W-1:0] idx);
    logic [DEPTH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// Wrap-bit pointer: W-1 index bits plus an MSB that toggles on roll-over.
// Clear wins over increment.
module queue_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer: clear, advance by one, or hold.
  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Pointer register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/queue_ctrl.sv
// Pointer/flag controller for the 8-entry register-file queue. Holds no
// data: it drives the storage row load enables and the read-mux select.
//
// Handshake: a push is accepted on an edge where push_valid && push_ready,
// a pop on an edge where pop_valid && pop_ready. Both ready/valid outputs
// depend only on registered state, never on the partner's inputs, and
// flush suppresses both transfers in its cycle.
module queue_ctrl
  import queue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_,
  input  logic             push_valid,
  output logic             push_ready,
  output logic             pop_valid,
  input  logic             pop_ready,
  input  logic             flush,
  output logic [DEPTH-1:0] wr_en,
  output logic [PTR_W-1:0] rd_sel,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf,
  output q_state_e         dbg_st
);

  logic [PTR_W:0] head, tail;
  logic [PTR_W:0] cnt_next;
  logic           push_fire, pop_fire;
  q_state_e       st_q, st_d;
  logic           ovf_q, ovf_d, udf_q, udf_d;

  // Flags come from the FSM; they track the pointer compare by construction.
  assign full       = (st_q == ST_FULL);
  assign empty      = (st_q == ST_EMPTY);
  assign push_ready = ~full;
  assign pop_valid  = ~empty;

  assign push_fire = push_valid & ~full & ~flush;
  assign pop_fire  = pop_ready & ~empty & ~flush;

  // Occupancy is the pointer difference mod 16; wrap bits make 8 distinct from 0.
  assign count    = tail - head;
  assign cnt_next = count + {{PTR_W{1'b0}}, push_fire} - {{PTR_W{1'b0}}, pop_fire};

  // Row load enable: only while out of reset so a held reset never writes.
  assign wr_en  = (push_fire & reset_) ? onehot8(tail[PTR_W-1:0]) : '0;
  assign rd_sel = head[PTR_W-1:0];

  assign ovf    = ovf_q;
  assign udf    = udf_q;
  assign dbg_st = st_q;

  queue_ptr #(.W(PTR_W + 1)) u_head (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (flush),
    .inc    (pop_fire),
    .ptr    (head)
  );

  queue_ptr #(.W(PTR_W + 1)) u_tail (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (flush),
    .inc    (push_fire),
    .ptr    (tail)
  );

  // Control FSM next state, steered by the post-edge occupancy.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_EMPTY:  if (push_fire) st_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (cnt_next == CNT_FULL)      st_d = ST_FULL;
        else if (cnt_next == '0)       st_d = ST_EMPTY;
      end
      ST_FULL:   if (pop_fire) st_d = ST_ACTIVE;
      default:   st_d = ST_EMPTY;
    endcase
    if (flush) st_d = ST_EMPTY;
  end

  // Sticky error flags: a rejected request leaves a mark until flush/reset.
  always_comb begin
    ovf_d = ovf_q | (push_valid & full);
    udf_d = udf_q | (pop_ready & empty);
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // State and error-flag registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      st_q  <= ST_EMPTY;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

endmodule
